// File: rtl/core_mem_arbiter_if.sv
// Signal bundle between the core's two memory requesters, the arbiter and the
// single word-addressed memory bus.
//
// Handshake: x_start is a one-cycle request pulse; the requester then waits for
// the matching one-cycle x_ready pulse, with read data valid in that same
// cycle. A new x_start may coincide with x_ready but never precede it.
// bus_start / bus_ready follow the same pulse protocol toward the memory.
interface core_mem_arbiter_if;
    logic        insn_start;
    logic [29:0] insn_addr;
    logic        insn_ready;
    logic [31:0] insn_data_rd;

    logic        data_start;
    logic        data_write;
    logic [29:0] data_addr;
    logic [31:0] data_data_wr;
    logic        data_lock;
    logic        data_ready;
    logic [31:0] data_data_rd;

    logic        bus_start;
    logic        bus_write;
    logic [29:0] bus_addr;
    logic [31:0] bus_data_wr;
    logic        bus_ready;
    logic [31:0] bus_data_rd;

    // Arbiter view: takes requests and bus completions, drives readies and bus.
    modport slave (
        input  insn_start, insn_addr,
        input  data_start, data_write, data_addr, data_data_wr, data_lock,
        input  bus_ready, bus_data_rd,
        output insn_ready, insn_data_rd, data_ready, data_data_rd,
        output bus_start, bus_write, bus_addr, bus_data_wr
    );

    // Environment view: requesters plus the memory behind the bus.
    modport master (
        output insn_start, insn_addr,
        output data_start, data_write, data_addr, data_data_wr, data_lock,
        output bus_ready, bus_data_rd,
        input  insn_ready, insn_data_rd, data_ready, data_data_rd,
        input  bus_start, bus_write, bus_addr, bus_data_wr
    );
endinterface

// File: rtl/core_mem_arbiter.sv
// Two-port memory arbiter: instruction fetch and load/store share one bus.
// One queued request per port, one bus transfer in flight, data has priority,
// and data_lock keeps the bus with the load/store unit across burst beats.
// Optional macro CORE_MEM_ARB_FAIR_EN: after STREAK_MAX consecutive data
// grants with fetch waiting, the next unlocked grant goes to fetch.
// STREAK_MAX must fit the 3-bit streak counter (1..7).
module core_mem_arbiter #(
    parameter int STREAK_MAX = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    core_mem_arbiter_if.slave   mem
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        BUSY_INSN = 2'd1,
        BUSY_DATA = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        pend_insn_q, pend_insn_d;
    logic        pend_data_q, pend_data_d;
    logic [29:0] insn_addr_q, insn_addr_d;
    logic [29:0] data_addr_q, data_addr_d;
    logic        data_write_q, data_write_d;
    logic [31:0] data_wdata_q, data_wdata_d;
    logic        owner_data_q, owner_data_d;
    logic        bus_start_q, bus_start_d;
    logic        bus_write_q, bus_write_d;
    logic [29:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;

    logic        pend_insn_now, pend_data_now;
    logic        grant_point, lock_hold, force_insn;
    logic        grant_insn, grant_data;

`ifdef CORE_MEM_ARB_FAIR_EN
    localparam logic [2:0] STREAK_LIM = 3'(STREAK_MAX);
    logic [2:0]  streak_q, streak_d;

    // Fetch is owed a turn once data has won STREAK_MAX times in a row; a lock wins.
    assign force_insn = !mem.data_lock && pend_insn_now && (streak_q >= STREAK_LIM);

    // Count data grants made while fetch waits; any fetch grant or idle fetch clears it.
    always_comb begin
        streak_d = streak_q;
        if (!pend_insn_now || grant_insn) begin
            streak_d = 3'd0;
        end else if (grant_data && streak_q != 3'd7) begin
            streak_d = streak_q + 3'd1;
        end
    end

    // Streak counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) streak_q <= 3'd0;
        else        streak_q <= streak_d;
    end
`else
    assign force_insn = 1'b0;
`endif

    // Arbitration: a start pulse in this cycle already counts as pending.
    always_comb begin
        pend_insn_now = pend_insn_q | mem.insn_start;
        pend_data_now = pend_data_q | mem.data_start;
        grant_point   = (state_q == IDLE) || mem.bus_ready;
        lock_hold     = mem.data_lock && owner_data_q;
        grant_insn    = 1'b0;
        grant_data    = 1'b0;
        if (grant_point) begin
            if (lock_hold) begin
                grant_data = pend_data_now;
            end else if (pend_data_now && !force_insn) begin
                grant_data = 1'b1;
            end else if (pend_insn_now) begin
                grant_insn = 1'b1;
            end
        end
    end

    // Next state: BUSY_winner on a grant, IDLE when the outstanding transfer ends.
    always_comb begin
        state_d = state_q;
        if (grant_data) begin
            state_d = BUSY_DATA;
        end else if (grant_insn) begin
            state_d = BUSY_INSN;
        end else if (mem.bus_ready && state_q != IDLE) begin
            state_d = IDLE;
        end
    end

    // Request slots, owner tracking and the registered bus command.
    always_comb begin
        insn_addr_d  = mem.insn_start ? mem.insn_addr : insn_addr_q;
        data_addr_d  = mem.data_start ? mem.data_addr : data_addr_q;
        data_write_d = mem.data_start ? mem.data_write : data_write_q;
        data_wdata_d = mem.data_start ? mem.data_data_wr : data_wdata_q;
        pend_insn_d  = pend_insn_now && !grant_insn;
        pend_data_d  = pend_data_now && !grant_data;
        owner_data_d = owner_data_q;
        bus_start_d  = grant_insn || grant_data;
        bus_write_d  = bus_write_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        if (grant_data) begin
            owner_data_d = 1'b1;
            bus_write_d  = data_write_d;
            bus_addr_d   = data_addr_d;
            bus_wdata_d  = data_wdata_d;
        end else if (grant_insn) begin
            // Write data is left as is for fetches; only address and direction change.
            owner_data_d = 1'b0;
            bus_write_d  = 1'b0;
            bus_addr_d   = insn_addr_d;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pend_insn_q  <= 1'b0;
            pend_data_q  <= 1'b0;
            insn_addr_q  <= '0;
            data_addr_q  <= '0;
            data_write_q <= 1'b0;
            data_wdata_q <= '0;
            owner_data_q <= 1'b0;
            bus_start_q  <= 1'b0;
            bus_write_q  <= 1'b0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            pend_insn_q  <= pend_insn_d;
            pend_data_q  <= pend_data_d;
            insn_addr_q  <= insn_addr_d;
            data_addr_q  <= data_addr_d;
            data_write_q <= data_write_d;
            data_wdata_q <= data_wdata_d;
            owner_data_q <= owner_data_d;
            bus_start_q  <= bus_start_d;
            bus_write_q  <= bus_write_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
        end
    end

    assign mem.bus_start    = bus_start_q;
    assign mem.bus_write    = bus_write_q;
    assign mem.bus_addr     = bus_addr_q;
    assign mem.bus_data_wr  = bus_wdata_q;
    assign mem.insn_ready   = mem.bus_ready && (state_q == BUSY_INSN);
    assign mem.data_ready   = mem.bus_ready && (state_q == BUSY_DATA);
    assign mem.insn_data_rd = mem.bus_data_rd;
    assign mem.data_data_rd = mem.bus_data_rd;
endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed bench for core_mem_arbiter. Inputs change on the falling edge and
// outputs are sampled 1 ns later, well away from the rising edge.
module tb_core_mem_arbiter;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    core_mem_arbiter_if mem ();

    core_mem_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mem   (mem)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic clear_starts();
        mem.insn_start = 1'b0;
        mem.data_start = 1'b0;
    endtask

    task automatic drive_insn(input logic [29:0] a);
        mem.insn_start = 1'b1;
        mem.insn_addr  = a;
    endtask

    task automatic drive_data(input logic wr, input logic [29:0] a, input logic [31:0] d);
        mem.data_start   = 1'b1;
        mem.data_write   = wr;
        mem.data_addr    = a;
        mem.data_data_wr = d;
    endtask

    initial begin
        logic        fair_on;
        logic [29:0] exp_addr;
        total = 0;
        bad   = 0;
`ifdef CORE_MEM_ARB_FAIR_EN
        fair_on = 1'b1;
`else
        fair_on = 1'b0;
`endif
        rst_n            = 1'b0;
        mem.insn_start   = 1'b0;
        mem.insn_addr    = '0;
        mem.data_start   = 1'b0;
        mem.data_write   = 1'b0;
        mem.data_addr    = '0;
        mem.data_data_wr = '0;
        mem.data_lock    = 1'b0;
        mem.bus_ready    = 1'b1;
        mem.bus_data_rd  = 32'h5555_AAAA;

        // reset state, with a stray bus_ready that must not leak through
        step(); #1;
        chk("rst_bus_start", 32'(mem.bus_start), 32'd0);
        chk("rst_bus_write", 32'(mem.bus_write), 32'd0);
        chk("rst_bus_addr", 32'(mem.bus_addr), 32'd0);
        chk("rst_bus_data_wr", mem.bus_data_wr, 32'd0);
        chk("rst_insn_ready", 32'(mem.insn_ready), 32'd0);
        chk("rst_data_ready", 32'(mem.data_ready), 32'd0);
        step();
        mem.bus_ready = 1'b0;
        rst_n = 1'b1;

        // single fetch
        step(); drive_insn(30'h100);
        step(); clear_starts(); #1;
        chk("fetch_bus_start", 32'(mem.bus_start), 32'd1);
        chk("fetch_bus_addr", 32'(mem.bus_addr), 32'h100);
        chk("fetch_bus_write", 32'(mem.bus_write), 32'd0);
        step(); #1;
        chk("fetch_start_one_cycle", 32'(mem.bus_start), 32'd0);
        step();
        step(); mem.bus_ready = 1'b1; mem.bus_data_rd = 32'hDEAD_BEEF; #1;
        chk("fetch_insn_ready", 32'(mem.insn_ready), 32'd1);
        chk("fetch_insn_data_rd", mem.insn_data_rd, 32'hDEAD_BEEF);
        chk("fetch_data_ready", 32'(mem.data_ready), 32'd0);
        step(); mem.bus_ready = 1'b0; #1;
        chk("fetch_ready_drop", 32'(mem.insn_ready), 32'd0);

        // collision: data wins, fetch follows right after data completes
        step(); drive_insn(30'h100); drive_data(1'b1, 30'h20, 32'h1234_5678);
        step(); clear_starts(); #1;
        chk("coll_first_start", 32'(mem.bus_start), 32'd1);
        chk("coll_first_addr", 32'(mem.bus_addr), 32'h20);
        chk("coll_first_write", 32'(mem.bus_write), 32'd1);
        chk("coll_first_wdata", mem.bus_data_wr, 32'h1234_5678);
        step(); mem.bus_ready = 1'b1; mem.bus_data_rd = 32'h0; #1;
        chk("coll_data_ready", 32'(mem.data_ready), 32'd1);
        chk("coll_insn_ready_low", 32'(mem.insn_ready), 32'd0);
        step(); mem.bus_ready = 1'b0; #1;
        chk("coll_insn_start", 32'(mem.bus_start), 32'd1);
        chk("coll_insn_addr", 32'(mem.bus_addr), 32'h100);
        chk("coll_insn_write", 32'(mem.bus_write), 32'd0);
        chk("coll_wdata_held", mem.bus_data_wr, 32'h1234_5678);
        step(); mem.bus_ready = 1'b1; mem.bus_data_rd = 32'h0BAD_F00D; #1;
        chk("coll_insn_ready", 32'(mem.insn_ready), 32'd1);
        chk("coll_insn_data", mem.insn_data_rd, 32'h0BAD_F00D);
        step(); mem.bus_ready = 1'b0;

        // locked burst of four loads, fetch arrives during beat 1
        mem.data_lock = 1'b1;
        for (int b = 0; b < 4; b++) begin
            drive_data(1'b0, 30'(32'h40 + b), 32'h0);
            if (b == 1) drive_insn(30'h200);
            #1;
            if (b > 0) chk("lock_gap_no_start", 32'(mem.bus_start), 32'd0);
            step(); clear_starts(); #1;
            chk("lock_beat_start", 32'(mem.bus_start), 32'd1);
            chk("lock_beat_addr", 32'(mem.bus_addr), 32'h40 + 32'(b));
            step(); mem.bus_ready = 1'b1; mem.bus_data_rd = 32'hA0 + 32'(b); #1;
            chk("lock_beat_ready", 32'(mem.data_ready), 32'd1);
            chk("lock_beat_rdata", mem.data_data_rd, 32'hA0 + 32'(b));
            step(); mem.bus_ready = 1'b0;
        end
        #1 chk("lock_hold_1", 32'(mem.bus_start), 32'd0);
        step(); #1;
        chk("lock_hold_2", 32'(mem.bus_start), 32'd0);
        mem.data_lock = 1'b0;
        step(); #1;
        chk("unlock_insn_start", 32'(mem.bus_start), 32'd1);
        chk("unlock_insn_addr", 32'(mem.bus_addr), 32'h200);
        step(); mem.bus_ready = 1'b1; #1;
        chk("unlock_insn_ready", 32'(mem.insn_ready), 32'd1);
        step(); mem.bus_ready = 1'b0;

        // back-to-back: data queued behind a fetch issues with no idle cycle
        drive_insn(30'h300);
        step(); clear_starts(); #1;
        chk("b2b_insn_addr", 32'(mem.bus_addr), 32'h300);
        drive_data(1'b0, 30'h55, 32'h0);
        step(); clear_starts();
        step(); mem.bus_ready = 1'b1; #1;
        chk("b2b_insn_ready", 32'(mem.insn_ready), 32'd1);
        step(); mem.bus_ready = 1'b0; #1;
        chk("b2b_data_start", 32'(mem.bus_start), 32'd1);
        chk("b2b_data_addr", 32'(mem.bus_addr), 32'h55);
        step(); mem.bus_ready = 1'b1; #1;
        chk("b2b_data_ready", 32'(mem.data_ready), 32'd1);
        step(); mem.bus_ready = 1'b0;

        // continuous unlocked data with fetch waiting: 5th grant decides fairness
        drive_data(1'b0, 30'h60, 32'h0); drive_insn(30'h400);
        for (int g = 0; g < 5; g++) begin
            step(); clear_starts(); mem.bus_ready = 1'b0; #1;
            exp_addr = (g == 4 && fair_on) ? 30'h400 : 30'(32'h60 + g);
            chk("streak_start", 32'(mem.bus_start), 32'd1);
            chk("streak_addr", 32'(mem.bus_addr), 32'(exp_addr));
            step(); mem.bus_ready = 1'b1;
            if (g < 4) drive_data(1'b0, 30'(32'h61 + g), 32'h0);
            #1;
            chk("streak_insn_ready", 32'(mem.insn_ready), (g == 4 && fair_on) ? 32'd1 : 32'd0);
        end
        step(); clear_starts(); mem.bus_ready = 1'b0; #1;
        chk("streak_tail_addr", 32'(mem.bus_addr), fair_on ? 32'h64 : 32'h400);
        step(); mem.bus_ready = 1'b1;
        step(); mem.bus_ready = 1'b0;

        // reset mid-transfer with fetch queued, then a stale bus_ready
        drive_data(1'b1, 30'h70, 32'hCAFE_F00D);
        step(); clear_starts(); #1;
        chk("mid_data_start", 32'(mem.bus_start), 32'd1);
        drive_insn(30'h500);
        step(); clear_starts();
        #2 rst_n = 1'b0; mem.bus_ready = 1'b1; #1;
        chk("mid_rst_bus_start", 32'(mem.bus_start), 32'd0);
        chk("mid_rst_bus_write", 32'(mem.bus_write), 32'd0);
        chk("mid_rst_bus_addr", 32'(mem.bus_addr), 32'd0);
        chk("mid_rst_bus_data_wr", mem.bus_data_wr, 32'd0);
        chk("mid_rst_data_ready", 32'(mem.data_ready), 32'd0);
        step(); rst_n = 1'b1; #1;
        chk("stale_insn_ready", 32'(mem.insn_ready), 32'd0);
        chk("stale_data_ready", 32'(mem.data_ready), 32'd0);
        step(); mem.bus_ready = 1'b0; #1;
        chk("stale_no_grant_1", 32'(mem.bus_start), 32'd0);
        step(); #1;
        chk("stale_no_grant_2", 32'(mem.bus_start), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/core_mem_arbiter.md
Name: core_mem_arbiter

Overview:
- Shares the core's single word-addressed memory port between two requesters: instruction fetch (insn) and the load/store unit (data).
- Each requester uses a start-pulse / ready-pulse handshake: one outstanding transfer per requester.
- The arbiter queues one request per port, issues at most one bus transfer at a time and routes ready and read data back to the owner.
- data_lock keeps the bus with the load/store unit for the whole of a multi-register transfer.

Parameters:
- STREAK_MAX, 4: consecutive data grants allowed while insn waits (used only with CORE_MEM_ARB_FAIR_EN).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- insn_start  in  1  one-cycle fetch request pulse
- insn_addr  in  30  fetch word address
- insn_ready  out  1  fetch done pulse
- insn_data_rd  out  32  fetch read data, valid with insn_ready
- data_start  in  1  one-cycle load/store request pulse
- data_write  in  1  1=store, 0=load
- data_addr  in  30  data word address
- data_data_wr  in  32  store data
- data_lock  in  1  hold bus for data between burst beats
- data_ready  out  1  data done pulse
- data_data_rd  out  32  load data, valid with data_ready
- bus_start  out  1  one-cycle bus request pulse
- bus_write  out  1  bus write enable
- bus_addr  out  30  bus word address
- bus_data_wr  out  32  bus write data
- bus_ready  in  1  bus done pulse
- bus_data_rd  in  32  bus read data

Behaviour:
- Reset: async on rst_n low.
  - State IDLE; both pending flags 0; streak counter 0.
  - bus_start, bus_write, bus_addr, bus_data_wr all 0.
  - insn_ready and data_ready are 0 (gated by state).
- Capture: x_start sets pending_x and latches addr, plus write and data for the data port. A requester must not pulse start again before its ready. A start in the same cycle as that port's ready is legal and is captured.
- States: IDLE, BUSY_INSN, BUSY_DATA. BUSY_x means a bus transfer is outstanding for x.
- Grant point: IDLE, or a BUSY state in the cycle bus_ready=1. A start pulse arriving in the same cycle counts as pending.
- Grant order:
  1. If data_lock=1 and the last owner was data: only data may be granted. If data is not pending, go to or stay in IDLE, holding the bus for data.
  2. Otherwise data wins over insn when both are pending.
  3. Otherwise grant whichever port is pending.
- Grant action, registered:
  - bus_start=1 for exactly one cycle.
  - bus_addr, bus_write and bus_data_wr load from the winner's slot. bus_write=0 and bus_data_wr is held for insn.
  - The winner's pending flag clears; state becomes BUSY_winner.
  - bus_addr, bus_write and bus_data_wr hold until the next grant.
- Latency: start at edge N with the bus idle -> bus_start high in cycle N+1. Back-to-back: bus_ready at N with another request pending -> bus_start in N+1, with no IDLE cycle in between.
- Completion:
  - insn_ready = bus_ready && BUSY_INSN.
  - data_ready = bus_ready && BUSY_DATA.
  - Both are combinational.
  - insn_data_rd and data_data_rd pass bus_data_rd straight through.
  - State returns to IDLE unless a new grant is made.
- bus_ready while IDLE (e.g. a stale transfer after reset) is ignored. No ready output is raised.
- data_lock falling while data is not pending releases the bus. A pending insn is granted at the next grant point, which is the next cycle if IDLE.

Optional Feature:
- CORE_MEM_ARB_FAIR_EN defined:
  - A 3-bit-or-wider streak counter counts consecutive data grants while pending_insn=1.
  - When the count reaches STREAK_MAX and data_lock=0, the next grant goes to insn even if data is pending.
  - The counter clears on any insn grant or when insn is not pending.
  - data_lock always overrides fairness.
- Not defined: strict data priority, and no counter is instantiated.

Test Plan:
- Single fetch: insn_start with insn_addr=0x100. Required: bus_start next cycle, bus_addr=0x100, bus_write=0. Bus answers bus_ready with bus_data_rd=0xDEADBEEF 3 cycles later. Required: insn_ready in the same cycle with insn_data_rd=0xDEADBEEF; data_ready stays 0.
- Collision: insn_start and data_start (store, addr 0x20, data 0x12345678) in the same cycle. Required:
  - Data is issued first, with bus_write=1.
  - On its bus_ready, data_ready pulses.
  - Insn is issued the next cycle with bus_addr=0x100.
- Locked burst: data_lock=1 and 4 data beats at 0x40..0x43, each start one cycle after the previous data_ready. insn_start arrives during beat 1. Required: insn is not granted until the cycle after data_lock falls following beat 4.
- Back-to-back: data pending when bus_ready for an insn transfer arrives. Required: bus_start in the very next cycle, with no idle cycle.
- Reset mid-transfer: rst_n low during BUSY_DATA with both ports pending. Required: all outputs 0 immediately. A later stale bus_ready produces no insn_ready or data_ready.
- With CORE_MEM_ARB_FAIR_EN and STREAK_MAX=4: continuous unlocked data requests with insn pending. Required: the 5th grant goes to insn.
